boot_loader_ctrl: RTL
=====================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameters SHALL be: IMEM_WORDS, default 64, instruction-memory depth in words; HOLD_CYCLES, default 4, core-reset hold after load; TIMEOUT, default 100000, run-cycle limit; DONE_ADDR, default 32'h508, completion store address; PASS_DATA, default 32'd2047, store value meaning pass.
REQ-002 clk  input  1  single clock, all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse that begins a load-and-run session.
REQ-005 ld_valid  input  1  program word available; ld_data  input  32  the word; ld_last  input  1  final word of the program.
REQ-006 ld_ready  output  1  controller accepts a word this cycle.
REQ-007 core_reset  output  1  reset to the core.
REQ-008 InstrWrite  output  1, WriteInst  output  32, WriteAdress  output  32  instruction-memory write port to the core.
REQ-009 MemWrite  input  1, ALUResult  input  32, WriteData  input  32  data-store monitor taps from the core.
REQ-010 busy, done, pass, fail, timeout  output  1 each  status; cycle_count  output  32  run cycles elapsed.

Function
REQ-011 The FSM SHALL have the states IDLE, LOAD, HOLD, RUN and DONE.
REQ-012 In IDLE and DONE, core_reset=1 and ld_ready=0, and start SHALL move to LOAD, clear addr, cycle_count and all status flags.
REQ-013 start SHALL be ignored in LOAD, HOLD and RUN, and ld_valid SHALL be ignored outside LOAD.
REQ-014 In LOAD, ld_ready=1, and each beat with ld_valid&ld_ready SHALL be accepted, so that WriteInst=ld_data, WriteAdress=addr and InstrWrite=1 are registered for exactly the next cycle, then addr+=4.
REQ-015 InstrWrite SHALL be 0 in every cycle not following an accepted beat, and WriteInst/WriteAdress SHALL hold their last values.
REQ-016 An accepted beat with ld_last=1, or one at addr=(IMEM_WORDS-1)*4, SHALL end LOAD and move to HOLD, with ld_ready=0 from the next cycle; words beyond depth are never accepted.
REQ-017 HOLD SHALL keep core_reset=1 for HOLD_CYCLES cycles, counted after the final InstrWrite cycle, then move to RUN.
REQ-018 RUN SHALL drive core_reset=0 and increment cycle_count once per cycle, saturating at 32'hFFFFFFFF.
REQ-019 In RUN, MemWrite=1 with ALUResult==DONE_ADDR SHALL set pass (WriteData==PASS_DATA) or fail (otherwise) and move to DONE the next cycle.
REQ-020 In RUN, cycle_count==TIMEOUT without a completion store SHALL set timeout and move to DONE.
REQ-021 A completion store in the same cycle as the timeout condition SHALL win: pass or fail is set and timeout stays 0.
REQ-022 done=1 only in DONE; busy=1 in LOAD, HOLD and RUN; pass/fail/timeout are mutually exclusive and sticky until the next start.
REQ-023 In DONE, core_reset SHALL be 1 and cycle_count SHALL freeze.
REQ-024 MemWrite to any other address SHALL be ignored.

Reset
REQ-025 On reset: state=IDLE, core_reset=1, ld_ready=0, InstrWrite=0, WriteInst=0, WriteAdress=0, addr=0, cycle_count=0, and all status flags 0.
REQ-026 Reset asserted mid-LOAD, HOLD or RUN SHALL abort the session in the same edge; the partly loaded memory contents are undefined to the controller.

Structure
REQ-027 The FSM state enum, DONE_ADDR and PASS_DATA defaults, and the word-size constant 4 SHALL live in a shared package, riscv_ctrl_pkg.
REQ-028 A single sub-module, run_monitor, SHALL hold the RUN cycle counter, completion detection and timeout compare; the load FSM stays in the top module.

Verification
REQ-029 Load of 3 words (0x00500093, 0x00108113, ld_last on the third) -> InstrWrite pulses at addresses 0, 4, 8; core_reset falls 4 cycles after the last pulse.
REQ-030 Load with ld_valid toggled every other cycle -> one write per accepted beat, with no duplicate or skipped addresses.
REQ-031 In RUN, MemWrite with ALUResult=0x508 and WriteData=2047 -> pass=1, done=1, core_reset=1 on the next cycle; MemWrite to 0x504 earlier is ignored.
REQ-032 Completion store 0x508 with data 1234 -> fail=1, pass=0.
REQ-033 TIMEOUT=50 with no store -> timeout=1 at cycle_count=50; a store at cycle 50 -> pass, not timeout.
REQ-034 IMEM_WORDS=4 and 6 words offered without ld_last -> exactly 4 written (0 to 12), ld_ready=0 afterwards; reset asserted during RUN -> all outputs return to reset values.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared types and constants for the boot loader.
// Imported by the controller, its load interface and run monitor.
package riscv_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE
  } state_t;

  localparam word_t DONE_ADDR_DFLT = 32'h508;
  localparam word_t PASS_DATA_DFLT = 32'd2047;
  localparam int    WORD_BYTES     = 4;

  function automatic word_t wordAddr(input int idx);
    return word_t'(idx * WORD_BYTES);
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// boot_loader_ctrl_if: program-word stream into the boot loader.
// The source drives valid/data/last, the loader returns ready.
interface boot_loader_ctrl_if;
  import riscv_ctrl_pkg::*;

  logic  ld_valid;
  word_t ld_data;
  logic  ld_last;
  logic  ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/run_monitor.sv
// run_monitor: counts RUN cycles and judges the completion store.
// A completion store beats a timeout seen in the same cycle.
module run_monitor import riscv_ctrl_pkg::*; #(
  parameter word_t TIMEOUT   = 32'd100000,
  parameter word_t DONE_ADDR = DONE_ADDR_DFLT,
  parameter word_t PASS_DATA = PASS_DATA_DFLT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  run,
  input  logic  MemWrite,
  input  word_t ALUResult,
  input  word_t WriteData,
  output logic  finish,
  output word_t cycle_count,
  output logic  pass,
  output logic  fail,
  output logic  timeout
);

  logic store;
  logic expired;

  assign store   = run && MemWrite && (ALUResult == DONE_ADDR);
  assign expired = run && (cycle_count == TIMEOUT);
  assign finish  = store || expired;

  // Sticky verdict flags and saturating run-cycle counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cycle_count <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
    end else if (store) begin
      pass <= (WriteData == PASS_DATA);
      fail <= (WriteData != PASS_DATA);
    end else if (expired) begin
      timeout <= 1'b1;
    end else if (run && cycle_count != '1) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: loads a program into the core's instruction
// memory, holds the core in reset, then runs and judges it.
module boot_loader_ctrl import riscv_ctrl_pkg::*; #(
  parameter int    IMEM_WORDS  = 64,
  parameter int    HOLD_CYCLES = 4,
  parameter word_t TIMEOUT     = 32'd100000,
  parameter word_t DONE_ADDR   = DONE_ADDR_DFLT,
  parameter word_t PASS_DATA   = PASS_DATA_DFLT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  boot_loader_ctrl_if.slave ld,
  output logic  core_reset,
  output logic  InstrWrite,
  output word_t WriteInst,
  output word_t WriteAdress,
  input  logic  MemWrite,
  input  word_t ALUResult,
  input  word_t WriteData,
  output logic  busy,
  output logic  done,
  output logic  pass,
  output logic  fail,
  output logic  timeout,
  output word_t cycle_count
);

  localparam word_t LAST_ADDR = wordAddr(IMEM_WORDS - 1);
  localparam word_t HOLD_END  = word_t'(HOLD_CYCLES);

  state_t state;
  word_t  addr;
  word_t  holdCnt;
  logic   ready;
  logic   idle;
  logic   finish;

  assign idle        = (state == IDLE) || (state == DONE);
  assign ld.ld_ready = ready;

  run_monitor #(
    .TIMEOUT   (TIMEOUT),
    .DONE_ADDR (DONE_ADDR),
    .PASS_DATA (PASS_DATA)
  ) u_mon (
    .clk         (clk),
    .reset       (reset),
    .clear       (start && idle),
    .run         (state == RUN),
    .MemWrite    (MemWrite),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .finish      (finish),
    .cycle_count (cycle_count),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout)
  );

  // Session FSM with registered handshake, write port and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready       <= 1'b0;
      core_reset  <= 1'b1;
      InstrWrite  <= 1'b0;
      WriteInst   <= '0;
      WriteAdress <= '0;
      addr        <= '0;
      holdCnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      InstrWrite <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            addr  <= '0;
            ready <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        LOAD: begin
          if (ld.ld_valid && ready) begin
            InstrWrite  <= 1'b1;
            WriteInst   <= ld.ld_data;
            WriteAdress <= addr;
            addr        <= addr + word_t'(WORD_BYTES);
            if (ld.ld_last || addr == LAST_ADDR) begin
              state   <= HOLD;
              ready   <= 1'b0;
              holdCnt <= '0;
            end
          end
        end
        HOLD: begin
          if (holdCnt == HOLD_END) begin
            state      <= RUN;
            core_reset <= 1'b0;
          end else begin
            holdCnt <= holdCnt + 32'd1;
          end
        end
        RUN: begin
          if (finish) begin
            state      <= DONE;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
